// File: rtl/booth_result_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_result_bcd_pkg
// Description : Shared types and constants for the Booth-product to BCD
//               converter: FSM state encoding, default widths, and
//               double-dabble constants.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_result_bcd_pkg;

    // Default product width and BCD digit count (10^DIGITS > 2^(W-1)).
    localparam int W_DEF       = 16;
    localparam int DIGITS_DEF  = 5;

    // Width of one packed BCD digit.
    localparam int BCD_W       = 4;

    // Digits at or above this value get +3 before each shift.
    localparam int ADD3_THRESH = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

endpackage : booth_result_bcd_pkg
`default_nettype wire

// File: rtl/booth_result_bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble correction for one BCD digit.
//               dout = (din >= 5) ? din + 3 : din
// Ports       : din  - current 4-bit scratch digit
//               dout - corrected digit, ready to be shifted left
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import booth_result_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    localparam logic [BCD_W-1:0] C_THRESH = BCD_W'(ADD3_THRESH);
    localparam logic [BCD_W-1:0] C_ADD    = BCD_W'(3);

    always_comb begin
        dout = (din >= C_THRESH) ? (din + C_ADD) : din;
    end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/booth_result_bcd.sv
`default_nettype none
// ============================================================================
// Module      : booth_result_bcd
// Description : Converts a signed two's-complement product into a sign flag
//               plus packed BCD magnitude using shift-and-add-3, one bit per
//               clock, with a start/busy/done handshake.
// Ports       : clk     - clock, rising edge
//               resetN  - synchronous active-low reset
//               start   - request conversion (sampled only when idle)
//               product - signed product to convert
//               busy    - conversion in progress
//               done    - one-cycle pulse when sign/bcd update
//               sign    - 1 = product was negative
//               bcd     - packed BCD magnitude, MS digit at top
// Revision    : 1.0 - initial release
// ============================================================================
module booth_result_bcd
    import booth_result_bcd_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      start,
    input  logic [W-1:0]              product,
    output logic                      busy,
    output logic                      done,
    output logic                      sign,
    output logic [BCD_W*DIGITS-1:0]   bcd
);

    localparam int              CNT_W  = $clog2(W);
    localparam int              SCR_W  = BCD_W * DIGITS;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [W-1:0]        mag_q,      mag_d;
    logic [SCR_W-1:0]    scratch_q,  scratch_d;
    logic                sign_src_q, sign_src_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                sign_q,     sign_d;
    logic [SCR_W-1:0]    bcd_q,      bcd_d;

    logic [SCR_W-1:0]    w_adj;
    logic [SCR_W+W-1:0]  w_shifted;
    logic [W-1:0]        w_abs;

    // Per-digit add-3 correction, all digits in parallel.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .din  (scratch_q[gi*BCD_W +: BCD_W]),
                .dout (w_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Corrected scratch and remaining magnitude shift together as one word.
    assign w_shifted = {w_adj, mag_q} << 1;

    // W-bit unsigned magnitude; the most negative value maps onto 2^(W-1)
    // without overflow because the result is read as unsigned.
    assign w_abs = product[W-1] ? (~product + W'(1)) : product;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        sign_src_d = sign_src_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sign_d     = sign_q;
        bcd_d      = bcd_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_src_d = product[W-1];
                    mag_d      = w_abs;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                scratch_d = w_shifted[SCR_W+W-1:W];
                mag_d     = w_shifted[W-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    // Publish only the completed result, never partials.
                    bcd_d   = w_shifted[SCR_W+W-1:W];
                    sign_d  = sign_src_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            sign_src_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sign_q     <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            sign_src_q <= sign_src_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sign_q     <= sign_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sign = sign_q;
    assign bcd  = bcd_q;

endmodule : booth_result_bcd
`default_nettype wire

// File: tb/tb_booth_result_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_result_bcd
// Description : Self-checking bench for booth_result_bcd: directed corner
//               cases plus randomized products against a decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_result_bcd;

    localparam int W      = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = 16;

    logic                  clk;
    logic                  resetN;
    logic                  start;
    logic [W-1:0]          product;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int overlap   = 0;
    int exp_dones = 0;

    booth_result_bcd #(.W(W), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .resetN  (resetN),
        .start   (start),
        .product (product),
        .busy    (busy),
        .done    (done),
        .sign    (sign),
        .bcd     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe handshake away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy && done) overlap++;
    end

    // Decimal reference: sign and base-10 digits of the signed value.
    function automatic logic [4*DIGITS:0] model(input logic [W-1:0] p);
        int v;
        int m;
        logic [4*DIGITS-1:0] b;
        v = int'($signed(p));
        m = (v < 0) ? -v : v;
        b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            b[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {(v < 0), b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; accepting edge is the next one.
    task automatic start_pulse(input logic [W-1:0] p);
        product = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Returns edges elapsed until done is seen, or -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] p,
                                input int n, input int exp_n);
        logic [4*DIGITS:0] m;
        m = model(p);
        exp_dones++;
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
        check({tag, "_sign"},    32'(sign), 32'(m[4*DIGITS]));
        check({tag, "_bcd"},     32'(bcd),  32'(m[4*DIGITS-1:0]));
    endtask

    initial begin
        int n;
        int snap;
        logic [W-1:0] p;

        resetN  = 1'b0;
        start   = 1'b0;
        product = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sign", 32'(sign), 32'd0);
        check("rst_bcd",  32'(bcd),  32'd0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner values.
        start_pulse(16'h0000);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(n);
        check_result("zero", 16'h0000, n, LAT);
        check("zero_bcd_const", 32'(bcd), 32'h00000);

        start_pulse(16'hFFFF);
        wait_done(n);
        check_result("neg_one", 16'hFFFF, n, LAT);
        check("neg_one_const", 32'({sign, bcd}), 32'h100001);

        start_pulse(16'h7FFF);
        wait_done(n);
        check_result("max_pos", 16'h7FFF, n, LAT);
        check("max_pos_const", 32'({sign, bcd}), 32'h032767);

        start_pulse(16'h8000);
        wait_done(n);
        check_result("min_neg", 16'h8000, n, LAT);
        check("min_neg_const", 32'({sign, bcd}), 32'h132768);

        // start during conversion is ignored; product is not re-sampled.
        start_pulse(16'h00FF);
        repeat (5) @(posedge clk);
        #1;
        product = 16'h0001;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        check("ignore_busy", 32'(busy), 32'd1);
        check("ignore_sign_hold", 32'(sign), 32'd1);
        wait_done(n);
        check_result("ignore", 16'h00FF, n, LAT - 6);
        check("ignore_const", 32'({sign, bcd}), 32'h000255);

        // start asserted in the done cycle is accepted immediately.
        start_pulse(16'hFF9C);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_hold_bcd", 32'(bcd), 32'h00255);
        wait_done(n);
        check_result("b2b", 16'hFF9C, n, LAT);
        check("b2b_const", 32'({sign, bcd}), 32'h100100);

        // Reset mid-conversion aborts without a done pulse.
        start_pulse(16'h1234);
        repeat (7) @(posedge clk);
        #1;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sign", 32'(sign), 32'd0);
        check("abort_bcd",  32'(bcd),  32'd0);
        snap = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(snap));

        start_pulse(16'hD8F1);
        wait_done(n);
        check_result("post_abort", 16'hD8F1, n, LAT);

        // Randomized products with occasional idle gaps.
        for (int k = 0; k < 1000; k++) begin
            p = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            start_pulse(p);
            wait_done(n);
            check_result("rand", p, n, LAT);
        end

        @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'(exp_dones));
        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_booth_result_bcd
`default_nettype wire
